// File: rtl/dispatcher_pkg.sv
// rtl/dispatcher_pkg.sv - shared dispatcher constants and the rename tag type
package dispatcher_pkg;

    localparam int TAG_W    = 6;
    localparam int NUM_TAGS = 64;

    typedef logic [TAG_W-1:0] tag_t;

endpackage

// File: rtl/tag_free_fifo.sv
// rtl/tag_free_fifo.sv - free rename-tag pool, reset full with tags 0..DEPTH-1 in order
module tag_free_fifo
    import dispatcher_pkg::*;
#(
    parameter int DEPTH      = NUM_TAGS,
    parameter int DATA_WIDTH = TAG_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] cdb_tag_tf,
    input  logic                  cdb_tag_tf_valid,
    input  logic                  ren_tf,
    output logic [DATA_WIDTH-1:0] tagout_tf,
    output logic                  ff_tf,
    output logic                  ef_tf
);

    localparam int PTR_W = $clog2(DEPTH) + 1;
    localparam int IDX_W = PTR_W - 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic                  pop_en;
    logic                  push_en;

    assign ef_tf     = (rd_ptr == wr_ptr);
    assign ff_tf     = (rd_ptr[IDX_W-1:0] == wr_ptr[IDX_W-1:0]) && (rd_ptr[IDX_W] != wr_ptr[IDX_W]);
    assign tagout_tf = mem[rd_ptr[IDX_W-1:0]];

    // A pop on a full pool frees the slot the push needs in the same edge; no bypass when empty.
    assign pop_en  = ren_tf && !ef_tf;
    assign push_en = cdb_tag_tf_valid && (!ff_tf || pop_en);

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= DATA_WIDTH'(i);
            end
            rd_ptr <= '0;
            wr_ptr <= PTR_W'(DEPTH);
        end else begin
            if (pop_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_en) begin
                mem[wr_ptr[IDX_W-1:0]] <= cdb_tag_tf;
                wr_ptr                 <= wr_ptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tag_free_fifo.sv
// tb/tb_tag_free_fifo.sv - directed self-checking bench for tag_free_fifo
module tb_tag_free_fifo;
    import dispatcher_pkg::*;

    logic clk;
    logic rst;
    tag_t cdb_tag_tf;
    logic cdb_tag_tf_valid;
    logic ren_tf;
    tag_t tagout_tf;
    logic ff_tf;
    logic ef_tf;

    int checks;
    int errors;

    tag_free_fifo #(.DEPTH(NUM_TAGS), .DATA_WIDTH(TAG_W)) tag_fifo (
        .clk              (clk),
        .rst              (rst),
        .cdb_tag_tf       (cdb_tag_tf),
        .cdb_tag_tf_valid (cdb_tag_tf_valid),
        .ren_tf           (ren_tf),
        .tagout_tf        (tagout_tf),
        .ff_tf            (ff_tf),
        .ef_tf            (ef_tf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
    endtask

    task automatic pop_once();
        ren_tf = 1'b1;
        cyc();
        ren_tf = 1'b0;
    endtask

    task automatic push_once(input tag_t t);
        cdb_tag_tf       = t;
        cdb_tag_tf_valid = 1'b1;
        cyc();
        cdb_tag_tf_valid = 1'b0;
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        rst              = 1'b0;
        ren_tf           = 1'b0;
        cdb_tag_tf_valid = 1'b0;
        cdb_tag_tf       = '0;
        #1;

        do_reset();
        chk("reset_ff", ff_tf, 1);
        chk("reset_ef", ef_tf, 0);
        chk("reset_tag", tagout_tf, 0);

        pop_once();
        chk("pop1_tag", tagout_tf, 1);
        chk("pop1_ff", ff_tf, 0);
        pop_once();
        chk("pop2_tag", tagout_tf, 2);

        push_once(6'd1);
        chk("push1_ff", ff_tf, 0);
        push_once(6'd0);
        chk("push0_ff", ff_tf, 1);
        chk("push0_head", tagout_tf, 2);

        for (int i = 2; i < 64; i++) begin
            chk("recycle_head", tagout_tf, i);
            pop_once();
        end
        chk("recycled_head_1", tagout_tf, 1);
        pop_once();
        chk("recycled_head_0", tagout_tf, 0);

        do_reset();
        for (int i = 0; i < 64; i++) begin
            chk("drain_head", tagout_tf, i);
            chk("drain_not_empty", ef_tf, 0);
            pop_once();
        end
        chk("drain_ef", ef_tf, 1);
        chk("drain_ff", ff_tf, 0);
        pop_once();
        chk("pop_empty_ef", ef_tf, 1);
        chk("pop_empty_ff", ff_tf, 0);

        cdb_tag_tf       = 6'd5;
        cdb_tag_tf_valid = 1'b1;
        ren_tf           = 1'b1;
        cyc();
        cdb_tag_tf_valid = 1'b0;
        ren_tf           = 1'b0;
        chk("empty_pushpop_ef", ef_tf, 0);
        chk("empty_pushpop_tag", tagout_tf, 5);
        pop_once();
        chk("empty_again_ef", ef_tf, 1);

        do_reset();
        push_once(6'd9);
        chk("full_push_ff", ff_tf, 1);
        chk("full_push_tag", tagout_tf, 0);

        cdb_tag_tf       = 6'd9;
        cdb_tag_tf_valid = 1'b1;
        ren_tf           = 1'b1;
        cyc();
        cdb_tag_tf_valid = 1'b0;
        ren_tf           = 1'b0;
        chk("full_pushpop_ff", ff_tf, 1);
        chk("full_pushpop_tag", tagout_tf, 1);
        for (int i = 1; i < 64; i++) begin
            chk("full_tail_head", tagout_tf, i);
            pop_once();
        end
        chk("full_tail_9", tagout_tf, 9);
        chk("full_tail_ef", ef_tf, 0);

        do_reset();
        pop_once();
        pop_once();
        push_once(6'd0);
        rst              = 1'b0;
        ren_tf           = 1'b1;
        cdb_tag_tf       = 6'd33;
        cdb_tag_tf_valid = 1'b1;
        cyc();
        rst              = 1'b1;
        ren_tf           = 1'b0;
        cdb_tag_tf_valid = 1'b0;
        chk("midrst_ff", ff_tf, 1);
        chk("midrst_ef", ef_tf, 0);
        chk("midrst_tag", tagout_tf, 0);
        pop_once();
        chk("midrst_pop_tag", tagout_tf, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
